// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, info-vector bit indices and store-lane helpers for the load/store unit
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    RESP,
    ERR
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP,
    OP_LB,
    OP_LH,
    OP_LW,
    OP_LBU,
    OP_LHU,
    OP_SB,
    OP_SH,
    OP_SW
  } op_e;

  localparam int INFO_LB  = 7;
  localparam int INFO_LH  = 6;
  localparam int INFO_LW  = 5;
  localparam int INFO_LBU = 4;
  localparam int INFO_LHU = 3;
  localparam int INFO_SB  = 2;
  localparam int INFO_SH  = 1;
  localparam int INFO_SW  = 0;

  // Several set bits resolve to the highest-priority one; no bits is a NOP.
  function automatic op_e decode_op(input logic [7:0] info);
    if (info[INFO_LB])       return OP_LB;
    else if (info[INFO_LH])  return OP_LH;
    else if (info[INFO_LW])  return OP_LW;
    else if (info[INFO_LBU]) return OP_LBU;
    else if (info[INFO_LHU]) return OP_LHU;
    else if (info[INFO_SB])  return OP_SB;
    else if (info[INFO_SH])  return OP_SH;
    else if (info[INFO_SW])  return OP_SW;
    else                     return OP_NOP;
  endfunction

  function automatic logic is_store(input op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_misaligned(input op_e op, input logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: return off[0];
      OP_LW, OP_SW:         return |off;
      default:              return 1'b0;
    endcase
  endfunction

  // Loads always fetch the whole word, so they share the full strobe.
  function automatic logic [3:0] store_strb(input op_e op, input logic [1:0] off);
    case (op)
      OP_SB:   return 4'b0001 << off;
      OP_SH:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating the narrow datum across lanes lets the strobe alone pick the target bytes.
  function automatic logic [31:0] store_lanes(input op_e op, input logic [31:0] d);
    case (op)
      OP_SB:   return {4{d[7:0]}};
      OP_SH:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects the addressed byte/half of a read word and sign/zero extends it
module lsu_load_align
  import lsu_pkg::*;
(
  input  op_e         op,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select followed by extension according to the load flavour.
  always_comb begin
    byte_v = word[8*offset +: 8];
    half_v = offset[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LB:   data = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  data = {24'd0, byte_v};
      OP_LH:   data = {{16{half_v[15]}}, half_v};
      OP_LHU:  data = {16'd0, half_v};
      OP_LW:   data = word;
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - handshaked load/store unit driving a word-addressed memory port with read timeout
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int REG_WIDTH  = 5,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [7:0]            req_info_i,
  input  logic [WIDTH-1:0]      req_wdata_i,
  input  logic [REG_WIDTH-1:0]  req_rd_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_wstrb_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  output logic                  resp_valid_o,
  output logic [WIDTH-1:0]      resp_rdata_o,
  output logic [REG_WIDTH-1:0]  resp_rd_o,
  output logic                  resp_misalign_o,
  output logic                  resp_timeout_o,
  output logic                  busy_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e                state_q, state_d;
  op_e                   op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      wdata_q;
  logic [WIDTH-1:0]      rdata_q;
  logic [REG_WIDTH-1:0]  rd_q;
  logic [CW-1:0]         cnt_q;
  logic                  misalign_q;
  logic                  timeout_q;

  op_e                   req_op;
  logic                  accept;
  logic                  cnt_done;
  logic [WIDTH-1:0]      load_data;

  assign req_op   = decode_op(req_info_i);
  assign accept   = req_valid_i && (state_q == IDLE);
  assign cnt_done = (cnt_q == CW'(TIMEOUT - 1));

  lsu_load_align u_align (
    .op     (op_q),
    .offset (addr_q[1:0]),
    .word   (mem_rdata_i),
    .data   (load_data)
  );

  // State register; reset abandons any op in flight without a response.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and all outputs; outputs are pure functions of state and latched request.
  always_comb begin
    state_d         = state_q;
    req_ready_o     = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_we_o        = 1'b0;
    mem_addr_o      = '0;
    mem_wstrb_o     = 4'b0000;
    mem_wdata_o     = '0;
    resp_valid_o    = 1'b0;
    resp_rdata_o    = '0;
    resp_rd_o       = '0;
    resp_misalign_o = 1'b0;
    resp_timeout_o  = 1'b0;
    busy_o          = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (accept)
          state_d = (req_op == OP_NOP || is_misaligned(req_op, req_addr_i[1:0])) ? ERR : REQ;
      end
      REQ: begin
        mem_req_valid_o = 1'b1;
        mem_we_o        = is_store(op_q);
        mem_addr_o      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        mem_wstrb_o     = store_strb(op_q, addr_q[1:0]);
        mem_wdata_o     = is_store(op_q) ? store_lanes(op_q, wdata_q) : '0;
        if (mem_req_ready_i) state_d = is_store(op_q) ? RESP : WAIT;
      end
      WAIT: begin
        if (mem_rvalid_i || cnt_done) state_d = RESP;
      end
      RESP: begin
        resp_valid_o   = 1'b1;
        resp_rdata_o   = rdata_q;
        resp_rd_o      = rd_q;
        resp_timeout_o = timeout_q;
        state_d        = IDLE;
      end
      ERR: begin
        resp_valid_o    = 1'b1;
        resp_rd_o       = rd_q;
        resp_misalign_o = misalign_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, wait counter and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= OP_NOP;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q       <= req_op;
        addr_q     <= req_addr_i;
        wdata_q    <= req_wdata_i;
        rd_q       <= req_rd_i;
        misalign_q <= is_misaligned(req_op, req_addr_i[1:0]);
        timeout_q  <= 1'b0;
        rdata_q    <= '0;
      end
      if (state_q == REQ && mem_req_ready_i) cnt_q <= '0;
      if (state_q == WAIT) begin
        if (mem_rvalid_i)  rdata_q   <= load_data;
        else if (cnt_done) timeout_q <= 1'b1;
        else               cnt_q     <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - scoreboard bench for lsu_mem_ctrl with directed load/store/error vectors
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [7:0]  req_info_i;
  logic [31:0] req_wdata_i;
  logic [4:0]  req_rd_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic [4:0]  resp_rd_o;
  logic        resp_misalign_o;
  logic        resp_timeout_o;
  logic        busy_o;

  lsu_mem_ctrl #(.WIDTH(32), .ADDR_WIDTH(32), .REG_WIDTH(5), .TIMEOUT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_addr_i      (req_addr_i),
    .req_info_i      (req_info_i),
    .req_wdata_i     (req_wdata_i),
    .req_rd_i        (req_rd_i),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_we_o        (mem_we_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wstrb_o     (mem_wstrb_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_rvalid_i    (mem_rvalid_i),
    .mem_rdata_i     (mem_rdata_i),
    .resp_valid_o    (resp_valid_o),
    .resp_rdata_o    (resp_rdata_o),
    .resp_rd_o       (resp_rd_o),
    .resp_misalign_o (resp_misalign_o),
    .resp_timeout_o  (resp_timeout_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        mis;
    logic        to;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;
  int   resp_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Monitor: every response pulse is matched against the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid_o === 1'b1) begin
        resp_cyc = cyc;
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_resp: got rd %0d rdata %h to %b want no response", resp_rd_o, resp_rdata_o, resp_timeout_o);
        end else begin
          e = sb_q.pop_front();
          chk("resp_rdata", resp_rdata_o, e.rdata);
          chk("resp_rd", {27'd0, resp_rd_o}, {27'd0, e.rd});
          chk("resp_misalign", {31'd0, resp_misalign_o}, {31'd0, e.mis});
          chk("resp_timeout", {31'd0, resp_timeout_o}, {31'd0, e.to});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] addr, input logic [7:0] info, input logic [31:0] wd, input logic [4:0] rd);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_info_i  = info;
    req_wdata_i = wd;
    req_rd_i    = rd;
    @(negedge clk);
    chk("req_ready", {31'd0, req_ready_o}, 32'd1);
    acc_cyc = cyc;
    tick();
    req_valid_i = 1'b0;
    req_info_i  = 8'h00;
  endtask

  task automatic chk_mem(input logic we, input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd);
    @(negedge clk);
    chk("mem_req_valid", {31'd0, mem_req_valid_o}, 32'd1);
    chk("mem_we", {31'd0, mem_we_o}, {31'd0, we});
    chk("mem_addr", mem_addr_o, addr);
    chk("mem_wstrb", {28'd0, mem_wstrb_o}, {28'd0, strb});
    if (we) chk("mem_wdata", mem_wdata_o, wd);
  endtask

  task automatic run_load(input logic [31:0] addr, input logic [7:0] info, input logic [4:0] rd,
                          input logic [31:0] word, input int waits, input logic [31:0] exp_rdata);
    sb_q.push_back('{rdata: exp_rdata, rd: rd, mis: 1'b0, to: 1'b0});
    mem_req_ready_i = 1'b1;
    accept(addr, info, 32'd0, rd);
    chk_mem(1'b0, {addr[31:2], 2'b00}, 4'b1111, 32'd0);
    tick();
    repeat (waits) tick();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = word;
    tick();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'd0;
    tick();
    if (waits == 0) chk("load_latency", resp_cyc - acc_cyc, 32'd3);
  endtask

  task automatic run_store(input logic [31:0] addr, input logic [7:0] info, input logic [31:0] wd, input logic [4:0] rd,
                           input logic [31:0] eaddr, input logic [3:0] estrb, input logic [31:0] ewd, input int stall);
    sb_q.push_back('{rdata: 32'd0, rd: rd, mis: 1'b0, to: 1'b0});
    mem_req_ready_i = (stall == 0);
    accept(addr, info, wd, rd);
    for (int i = 0; i < stall; i++) begin
      chk_mem(1'b1, eaddr, estrb, ewd);
      tick();
    end
    mem_req_ready_i = 1'b1;
    chk_mem(1'b1, eaddr, estrb, ewd);
    tick();
    tick();
    if (stall == 0) chk("store_latency", resp_cyc - acc_cyc, 32'd2);
  endtask

  task automatic run_err(input logic [31:0] addr, input logic [7:0] info, input logic [4:0] rd, input logic mis);
    sb_q.push_back('{rdata: 32'd0, rd: rd, mis: mis, to: 1'b0});
    accept(addr, info, 32'hFFFF_FFFF, rd);
    @(negedge clk);
    chk("err_no_mem_req", {31'd0, mem_req_valid_o}, 32'd0);
    tick();
    chk("err_latency", resp_cyc - acc_cyc, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid_i = 1'b0;
    req_addr_i = 32'd0;
    req_info_i = 8'd0;
    req_wdata_i = 32'd0;
    req_rd_i = 5'd0;
    mem_req_ready_i = 1'b1;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = 32'd0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_mem_req_valid", {31'd0, mem_req_valid_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    run_load(32'h100, 8'h20, 5'd5,  32'hDEAD_BEEF, 2, 32'hDEAD_BEEF);
    run_load(32'h103, 8'h80, 5'd7,  32'h8012_3456, 0, 32'hFFFF_FF80);
    run_load(32'h103, 8'h10, 5'd8,  32'h8012_3456, 1, 32'h0000_0080);
    run_load(32'h102, 8'h08, 5'd9,  32'h8001_1234, 0, 32'h0000_8001);
    run_load(32'h102, 8'h40, 5'd10, 32'h8001_1234, 3, 32'hFFFF_8001);
    run_load(32'h101, 8'h90, 5'd11, 32'h0000_FF00, 0, 32'hFFFF_FFFF);

    run_store(32'h202, 8'h02, 32'h1234_ABCD, 5'd12, 32'h200, 4'b1100, 32'hABCD_ABCD, 3);
    run_store(32'h201, 8'h04, 32'h0000_005A, 5'd13, 32'h200, 4'b0010, 32'h5A5A_5A5A, 0);
    run_store(32'h300, 8'h01, 32'h1122_3344, 5'd14, 32'h300, 4'b1111, 32'h1122_3344, 0);

    run_err(32'h101, 8'h20, 5'd15, 1'b1);
    run_err(32'h103, 8'h02, 5'd16, 1'b1);
    run_err(32'h102, 8'h21, 5'd17, 1'b1);
    run_err(32'h104, 8'h00, 5'd18, 1'b0);

    sb_q.push_back('{rdata: 32'd0, rd: 5'd19, mis: 1'b0, to: 1'b1});
    accept(32'h40, 8'h20, 32'd0, 5'd19);
    chk_mem(1'b0, 32'h40, 4'b1111, 32'd0);
    tick();
    repeat (4) tick();
    tick();
    chk("timeout_latency", resp_cyc - acc_cyc, 32'd6);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1111_1111;
    tick();
    mem_rvalid_i = 1'b0;
    tick();
    tick();

    accept(32'h80, 8'h20, 32'd0, 5'd3);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_req_ready", {31'd0, req_ready_o}, 32'd1);
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    mem_rvalid_i = 1'b1;
    tick();
    mem_rvalid_i = 1'b0;
    tick();
    run_store(32'h0, 8'h04, 32'h0000_00A5, 5'd1, 32'h0, 4'b0001, 32'hA5A5_A5A5, 0);

    tick();
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Handshaked load/store unit that replaces the single-cycle, zero-latency memory access stage. It accepts one load/store per request, performs byte-lane alignment and write-strobe generation, and detects misalignment. It drives a valid/ready word-addressed memory port with variable read latency and a timeout counter, then returns sign/zero-extended load data with the destination register tag. It sits between execute and writeback; the core stalls while busy_o=1.

Parameters:
WIDTH, 32, data width; fixed at 32, with 4 byte lanes.
ADDR_WIDTH, 32, byte address width.
REG_WIDTH, 5, destination-register tag width.
TIMEOUT, 255, maximum cycles to wait for mem_rvalid_i before an error response; must be ≥1.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&&ready
req_addr_i  in  ADDR_WIDTH  byte address
req_info_i  in  8  {lb,lh,lw,lbu,lhu,sb,sh,sw}, bit7..bit0
req_wdata_i  in  WIDTH  store data, right-justified
req_rd_i  in  REG_WIDTH  destination tag
mem_req_valid_o  out  1  memory request valid
mem_req_ready_i  in  1  memory accepts request
mem_we_o  out  1  1=write
mem_addr_o  out  ADDR_WIDTH  word-aligned address, low 2 bits = 0
mem_wstrb_o  out  4  byte strobes
mem_wdata_o  out  WIDTH  lane-replicated store data
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  WIDTH  read word
resp_valid_o  out  1  one-cycle response pulse
resp_rdata_o  out  WIDTH  extended load data; 0 for stores and errors
resp_rd_o  out  REG_WIDTH  tag of the completed op
resp_misalign_o  out  1  misaligned access, valid with resp_valid_o
resp_timeout_o  out  1  read timed out, valid with resp_valid_o
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): FSM=IDLE. All outputs 0 except req_ready_o=1. Timeout counter=0. Reset during any state aborts the op with no response; a pending memory read is dropped.
- Decode: if several info bits are set, priority is lb>lh>lw>lbu>lhu>sb>sh>sw. Info=0 is a NOP.
- Misalignment: halfword ops with addr[0]=1, or word ops with addr[1:0]≠0.
- IDLE: req_ready_o=1. On accept, latch addr, op, wdata and rd, then go to:
  - ERR if the op is misaligned or a NOP.
  - REQ otherwise.
- ERR: pulse resp_valid_o next cycle. resp_misalign_o=1 for a misaligned op; all-zero flags for a NOP. No memory transaction. Return to IDLE.
- REQ: mem_req_valid_o=1. Outputs are held stable until mem_req_ready_i.
  - Strobe: sb → 4'b0001<<addr[1:0]; sh → 4'b0011<<addr[1:0]; sw → 4'b1111.
  - Write data: sb → {4{d[7:0]}}; sh → {2{d[15:0]}}; sw → d.
  - Loads: mem_we_o=0, strobe 4'b1111.
  - On handshake: a store goes to RESP (completes on acceptance, no rvalid awaited); a load goes to WAIT with the counter cleared.
- WAIT: count cycles while mem_rvalid_i=0.
  - On mem_rvalid_i: select the byte/half at addr[1:0] and extend per op; lw passes the word through. Go to RESP.
  - When the counter reaches TIMEOUT with no rvalid: go to RESP with resp_timeout_o=1 and rdata 0.
  - A late rvalid arriving in IDLE is ignored.
- RESP: resp_valid_o=1 for exactly one cycle with rdata, rd and flags. Next state IDLE. A new request is accepted no earlier than the following cycle, so throughput is one op per at least 3 cycles.
- Latency: load with zero-wait memory (ready=1 in REQ, rvalid the cycle after): accept → resp_valid 3 cycles later. Store: 2 cycles.
- Outside RESP/ERR, all resp_* outputs are 0. mem_* outputs are 0 outside REQ.

Decomposition:
- Package lsu_pkg holds:
  - State enum {IDLE, REQ, WAIT, RESP, ERR}.
  - Op enum decoded from the 8-bit info.
  - Bit-index constants for the info vector.
  - Strobe and lane-replication functions.
- One natural sub-module, lsu_load_align: combinational lane select plus sign/zero extension (op, offset, word → data), reused by future cache logic.

Test Plan:
- lw at 0x100, mem returns 0xDEADBEEF after 2 wait cycles → resp_rdata=0xDEADBEEF, tag echoed, flags 0.
- lb at 0x103 with word 0x80xxxxxx → rdata=0xFFFFFF80; lbu at the same address → 0x00000080; lhu at 0x102 with word 0x8001xxxx → 0x00008001.
- sh at 0x202 with data 0x1234ABCD → mem_addr=0x200, wstrb=4'b1100, wdata=0xABCDABCD, we=1. With mem_req_ready_i held low 3 cycles, outputs stay stable; resp pulses once, rdata=0.
- lw at 0x101 and sh at 0x103 → no mem_req_valid, resp_misalign=1 one cycle after accept.
- Load with mem_rvalid never asserted, TIMEOUT=4 → resp_timeout=1 after 4 WAIT cycles. A subsequent rvalid in IDLE causes no response.
- rst asserted in WAIT → next cycle IDLE, req_ready=1, no resp_valid. A new sb at 0x0 then gives wstrb=4'b0001.
